nrisc_run_controller: RTL

Parametrised execution controller for the nRisc core. It gates the core with a clock enable and counts executed cycles, so a run can be bounded. It stops the run on the core's `Encerra` halt or on a cycle limit. It also captures a rolling trace of PC and memory-write activity that can be read back after the run. The block sits between the top level and the nRisc core/memory banks and replaces ad-hoc stage counters and finish logic with synthesizable hardware.

---
 rtl/nrisc_run_controller.sv | 124 ++++++++++++
 1 files changed

// File: rtl/nrisc_run_controller.sv
// Run controller for the nRisc core: gates the core clock enable, bounds the run by
// Encerra or a cycle limit, and keeps a circular trace of PC/memory-write activity.
module nrisc_run_controller #(
  parameter int PC_WIDTH    = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int CNT_WIDTH   = 23,
  parameter int MAX_CYCLES  = 100,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [PC_WIDTH-1:0]                  pc,
  input  logic                                 encerra,
  input  logic                                 escreve_mem,
  input  logic [DATA_WIDTH-1:0]                endereco,
  input  logic [DATA_WIDTH-1:0]                dado,
  output logic                                 core_en,
  output logic [1:0]                           state,
  output logic                                 done,
  output logic                                 timeout,
  output logic [CNT_WIDTH-1:0]                 cycle_count,
  input  logic                                 trace_rd_en,
  output logic [PC_WIDTH+2*DATA_WIDTH:0]       trace_rd_data,
  output logic [$clog2(TRACE_DEPTH):0]         trace_count,
  output logic                                 trace_empty
);

  localparam int ENTRY_W = PC_WIDTH + 2*DATA_WIDTH + 1;
  localparam int PTR_W   = $clog2(TRACE_DEPTH);

  localparam logic [PTR_W-1:0]     PTR_ONE   = 1;
  localparam logic [PTR_W:0]       CNT_ONE   = 1;
  localparam logic [PTR_W:0]       CNT_FULL  = (PTR_W+1)'(TRACE_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CYC_ONE   = 1;
  localparam logic [CNT_WIDTH-1:0] CYC_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    HALTED  = 2'b10,
    TIMEOUT = 2'b11
  } runState_t;

  runState_t stateReg, stateNext;

  logic [CNT_WIDTH-1:0] cycleCountReg;
  logic [PTR_W-1:0]     wrPtrReg, rdPtrReg;
  logic [PTR_W:0]       countReg;
  logic [ENTRY_W-1:0]   rdDataReg;
  logic [ENTRY_W-1:0]   traceMem [TRACE_DEPTH];

  logic runStart, push, pop;
  logic [ENTRY_W-1:0] entry;

  assign entry = {escreve_mem, endereco, dado, pc};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  // Start has priority over a pop outside RUN; pops are ignored while running.
  always_comb begin
    stateNext = stateReg;
    runStart  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (stateReg)
      RUN: begin
        push = 1'b1;
        if (encerra)                      stateNext = HALTED;
        else if (cycleCountReg == CYC_LAST) stateNext = TIMEOUT;
      end
      default: begin
        if (start) begin
          stateNext = RUN;
          runStart  = 1'b1;
        end else if (trace_rd_en && countReg != '0) begin
          pop = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycleCountReg <= '0;
      wrPtrReg      <= '0;
      rdPtrReg      <= '0;
      countReg      <= '0;
      rdDataReg     <= '0;
    end else if (runStart) begin
      cycleCountReg <= '0;
      wrPtrReg      <= '0;
      rdPtrReg      <= '0;
      countReg      <= '0;
    end else if (push) begin
      cycleCountReg <= cycleCountReg + CYC_ONE;
      wrPtrReg      <= wrPtrReg + PTR_ONE;
      // Full buffer: the new entry overwrites the oldest one.
      if (countReg == CNT_FULL) rdPtrReg <= rdPtrReg + PTR_ONE;
      else                      countReg <= countReg + CNT_ONE;
    end else if (pop) begin
      rdDataReg <= traceMem[rdPtrReg];
      rdPtrReg  <= rdPtrReg + PTR_ONE;
      countReg  <= countReg - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push) traceMem[wrPtrReg] <= entry;
  end

  assign state         = stateReg;
  assign core_en       = (stateReg == RUN);
  assign done          = (stateReg == HALTED) || (stateReg == TIMEOUT);
  assign timeout       = (stateReg == TIMEOUT);
  assign cycle_count   = cycleCountReg;
  assign trace_rd_data = rdDataReg;
  assign trace_count   = countReg;
  assign trace_empty   = (countReg == '0);

endmodule
